// File: rtl/ssd_scanner.sv
// ssd_scanner
//   Time-multiplexed 4-digit seven-segment driver. A 16-bit hex value and
//   per-digit enables are captured into a pending buffer on `update`. They
//   are copied into the displayed (shadow) copy only at a frame boundary, so
//   one scan frame never mixes old and new data.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-high
//   value      hex value, nibble k -> digit k (digit 0 = rightmost)
//   digit_en   per-digit enable, 0 blanks the digit
//   update     single-cycle strobe capturing value/digit_en
//   blank      level, forces every anode off while high
//   an         anode selects, active-low, at most one low
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   frame_done one-cycle pulse following each frame wrap
//
// Parameter
//   REFRESH_DIV  clock cycles each digit is lit (minimum 2)

module ssd_scanner #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic        update,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_div_cnt;
  logic [1:0]       r_digit_idx;
  logic [15:0]      r_shadow_val;
  logic [3:0]       r_shadow_en;
  logic [15:0]      r_pend_val;
  logic [3:0]       r_pend_en;
  logic             r_pend;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_frame_done;

  logic             w_dwell_end;
  logic             w_boundary;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg_dec;
  logic             w_lit;
  logic [3:0]       w_an_dec;

  assign w_dwell_end = (r_div_cnt == CNT_LAST);
  assign w_boundary  = w_dwell_end && (r_digit_idx == 2'd3);

  // Dwell counter and digit scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt   <= '0;
      r_digit_idx <= '0;
    end else if (w_dwell_end) begin
      r_div_cnt   <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
    end else begin
      r_div_cnt   <= r_div_cnt + 1'b1;
    end
  end

  // Pending/shadow buffers. An update landing on the boundary cycle goes
  // straight to the shadow so it is shown in the very next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow_val <= '0;
      r_shadow_en  <= '0;
      r_pend_val   <= '0;
      r_pend_en    <= '0;
      r_pend       <= 1'b0;
    end else if (w_boundary) begin
      r_pend <= 1'b0;
      if (update) begin
        r_shadow_val <= value;
        r_shadow_en  <= digit_en;
      end else if (r_pend) begin
        r_shadow_val <= r_pend_val;
        r_shadow_en  <= r_pend_en;
      end
    end else if (update) begin
      r_pend_val <= value;
      r_pend_en  <= digit_en;
      r_pend     <= 1'b1;
    end
  end

  // Current digit selection and decode
  always_comb begin
    w_nibble = r_shadow_val[3:0];
    case (r_digit_idx)
      2'd0: w_nibble = r_shadow_val[3:0];
      2'd1: w_nibble = r_shadow_val[7:4];
      2'd2: w_nibble = r_shadow_val[11:8];
      2'd3: w_nibble = r_shadow_val[15:12];
      default: w_nibble = r_shadow_val[3:0];
    endcase
  end

  always_comb begin
    w_seg_dec = 7'h7F;
    case (w_nibble)
      4'h0: w_seg_dec = 7'h40;
      4'h1: w_seg_dec = 7'h79;
      4'h2: w_seg_dec = 7'h24;
      4'h3: w_seg_dec = 7'h30;
      4'h4: w_seg_dec = 7'h19;
      4'h5: w_seg_dec = 7'h12;
      4'h6: w_seg_dec = 7'h02;
      4'h7: w_seg_dec = 7'h78;
      4'h8: w_seg_dec = 7'h00;
      4'h9: w_seg_dec = 7'h10;
      4'hA: w_seg_dec = 7'h08;
      4'hB: w_seg_dec = 7'h03;
      4'hC: w_seg_dec = 7'h46;
      4'hD: w_seg_dec = 7'h21;
      4'hE: w_seg_dec = 7'h06;
      4'hF: w_seg_dec = 7'h0E;
      default: w_seg_dec = 7'h7F;
    endcase
  end

  assign w_lit    = r_shadow_en[r_digit_idx] & ~blank;
  assign w_an_dec = ~(4'b0001 << r_digit_idx);

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an         <= '1;
      r_seg        <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_lit ? w_an_dec : 4'hF;
      r_seg        <= w_lit ? w_seg_dec : 7'h7F;
      r_frame_done <= w_boundary;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ssd_scanner.sv
// tb_ssd_scanner
//   Directed bench for ssd_scanner with REFRESH_DIV=4 (16-cycle frames).
//   `disp_*` holds what the display should show in the current frame and
//   `nxt_*` what should appear from the next frame boundary onward.

module tb_ssd_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  digit_en = '0;
  logic        update = 1'b0;
  logic        blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] disp_val = '0;
  logic [3:0]  disp_en = '0;
  logic [15:0] nxt_val = '0;
  logic [3:0]  nxt_en = '0;
  bit          nxt_valid = 1'b0;

  ssd_scanner #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .digit_en   (digit_en),
    .update     (update),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;
      4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;
      4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;
      4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;
      4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic check3(input string tag, input logic [3:0] ea,
                        input logic [6:0] es, input logic ef);
    checks++;
    assert (an === ea) else begin
      failures++;
      $error("FAIL %s_an cyc=%0d got=%h exp=%h", tag, cyc, an, ea);
    end
    checks++;
    assert (seg === es) else begin
      failures++;
      $error("FAIL %s_seg cyc=%0d got=%h exp=%h", tag, cyc, seg, es);
    end
    checks++;
    assert (frame_done === ef) else begin
      failures++;
      $error("FAIL %s_fd cyc=%0d got=%b exp=%b", tag, cyc, frame_done, ef);
    end
  endtask

  // One clock; output after edge n reflects scan slot ((n-1)/4)%4.
  task automatic tick(input string tag);
    logic       b;
    int         slot;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ef;
    b = blank;
    @(posedge clk); #1;
    cyc++;
    slot = ((cyc - 1) / 4) % 4;
    if (disp_en[slot] && !b) begin
      ea = ~(4'b0001 << slot);
      es = hex7(disp_val[slot*4 +: 4]);
    end else begin
      ea = 4'hF;
      es = 7'h7F;
    end
    ef = (cyc % 16 == 0);
    check3(tag, ea, es, ef);
    if (ef && nxt_valid) begin
      disp_val  = nxt_val;
      disp_en   = nxt_en;
      nxt_valid = 1'b0;
    end
  endtask

  task automatic run_to(input int n, input string tag);
    while (cyc < n) tick(tag);
  endtask

  task automatic do_update(input logic [15:0] v, input logic [3:0] e, input string tag);
    value     = v;
    digit_en  = e;
    update    = 1'b1;
    nxt_val   = v;
    nxt_en    = e;
    nxt_valid = 1'b1;
    tick(tag);
    update    = 1'b0;
  endtask

  initial begin
    // Reset
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check3("reset", 4'hF, 7'h7F, 1'b0);
    rst = 1'b0;
    cyc = 0;

    // Two frames with nothing loaded: blank display, pulses at 16 and 32
    run_to(32, "idle");

    // Mid-frame update shown only from the next frame
    run_to(36, "pre_upd");
    do_update(16'h8105, 4'hF, "upd8105");
    run_to(80, "show8105");

    // Partial enables
    run_to(85, "pre_cece");
    do_update(16'hCECE, 4'b0101, "updCECE");
    run_to(112, "showCECE");

    // Two updates in one frame: latest wins
    run_to(115, "pre_1111");
    do_update(16'h1111, 4'hF, "upd1111");
    run_to(120, "pre_2222");
    do_update(16'h2222, 4'hF, "upd2222");
    run_to(144, "show2222");

    // Update sampled on the boundary edge shows in the immediately following frame
    run_to(159, "pre_bnd");
    do_update(16'h3333, 4'hF, "updbnd");
    run_to(176, "show3333");

    // Blank for 10 cycles mid-frame, scan phase undisturbed
    run_to(180, "pre_blank");
    blank = 1'b1;
    repeat (10) tick("blank");
    blank = 1'b0;
    run_to(208, "post_blank");

    // Async reset between edges while frame_done is high and digit 3 is lit
    #2 rst = 1'b1;
    #1;
    check3("async_rst", 4'hF, 7'h7F, 1'b0);
    @(posedge clk); #1;
    check3("rst_hold", 4'hF, 7'h7F, 1'b0);
    rst       = 1'b0;
    cyc       = 0;
    disp_val  = '0;
    disp_en   = '0;
    nxt_valid = 1'b0;
    run_to(32, "post_rst");

    // Display returns only after a fresh update and boundary
    run_to(37, "pre_a5f0");
    do_update(16'hA5F0, 4'b1011, "updA5F0");
    run_to(80, "showA5F0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
